// File: rtl/weight_fetch_pkg.sv
// Shared definitions for the weight fetch scheduler.
//   - fetch_state_t : fetch FSM states
//   - N_KW / N_BN   : kernel words and BN words per output channel
//   - wset_t        : one captured weight set (kernel, BN pair, channel index)
//   - set_xor       : XOR of all words of one set
// wset_t is sized by WF_DW / WF_CH_W. A top-level DW / CH_W override must
// match these values.
package weight_fetch_pkg;

    localparam int WF_DW   = 32;
    localparam int WF_CH_W = 8;
    localparam int N_KW    = 9;
    localparam int N_BN    = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        WAIT_DROP,
        GAP,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [N_KW*WF_DW-1:0] kernel;
        logic [N_BN*WF_DW-1:0] bn;
        logic [WF_CH_W-1:0]    ch;
    } wset_t;

    function automatic logic [WF_DW-1:0] set_xor(wset_t s);
        logic [WF_DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_KW; i++) acc ^= s.kernel[i*WF_DW +: WF_DW];
        for (int i = 0; i < N_BN; i++) acc ^= s.bn[i*WF_DW +: WF_DW];
        return acc;
    endfunction

endpackage

// File: rtl/weight_fetch_sched_buf.sv
// Two-entry ping-pong buffer of weight sets.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : empty the buffer (pointers and count to 0)
//   push, wr_data  : write one set into the write slot (ignored when full)
//   pop            : release the read slot (ignored when empty)
//   rd_data        : contents of the read slot, straight from the slot registers
//   full, empty    : occupancy flags
// Push and pop in the same cycle advance both pointers and keep the count.
module weight_pingpong_buf
    import weight_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  push,
    input  wset_t wr_data,
    input  logic  pop,
    output wset_t rd_data,
    output logic  full,
    output logic  empty
);

    wset_t      slot [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = slot[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= wr_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_sched.sv
// Weight fetch scheduler: walks the AXI weight reader over every output
// channel of a conv layer, captures each channel's 3x3 kernel and BN pair
// into a two-entry ping-pong buffer, and hands the sets to the conv/BN
// datapath so that fetch of channel k+1 overlaps consumption of channel k.
// Ports:
//   aclk, areset              : clock, asynchronous active-high reset
//   cfg_conv_bn_en, cfg_num_ch: layer config, sampled only at cmd_run
//   cmd_run, cmd_abort        : one-cycle start / abort pulses (abort wins)
//   rd_start, rd_ready, rd_next, rd_w, rd_bn : weight reader interface
//   cv_valid, cv_accept, cv_w, cv_bn, cv_ch  : datapath interface
//   busy, done                : status (done = one-cycle pulse at layer end)
//   chksum                    : only with WEIGHT_FETCH_SCHED_CHKSUM_EN defined;
//                               XOR of every word captured since run
//
// Handshakes:
//   reader   : rd_ready high means rd_w/rd_bn hold the current set. The set is
//              captured on the edge that leaves WAIT_RDY; rd_next then stays
//              high until rd_ready=0 is sampled, and is low for at least one
//              cycle before the next capture.
//   datapath : a set transfers on every edge where cv_valid & cv_accept;
//              cv_accept without cv_valid is ignored.
module weight_fetch_sched
    import weight_fetch_pkg::*;
#(
    parameter int DW   = WF_DW,
    parameter int CH_W = WF_CH_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_conv_bn_en,
    input  logic [CH_W-1:0]   cfg_num_ch,
    input  logic              cmd_run,
    input  logic              cmd_abort,
    output logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_next,
    input  logic [N_KW*DW-1:0] rd_w,
    input  logic [N_BN*DW-1:0] rd_bn,
    output logic              cv_valid,
    input  logic              cv_accept,
    output logic [N_KW*DW-1:0] cv_w,
    output logic [N_BN*DW-1:0] cv_bn,
    output logic [CH_W-1:0]   cv_ch,
    output logic              busy,
    output logic              done
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
    ,
    output logic [DW-1:0]     chksum
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [CH_W-1:0] n_ch;
    logic [CH_W-1:0] fch;
    logic            start_run;
    logic            capture;
    logic            buf_full;
    logic            buf_empty;
    wset_t           buf_wr;
    wset_t           buf_rd;

    assign start_run = (state == IDLE) & cmd_run & cfg_conv_bn_en & ~cmd_abort;
    assign capture   = (state == WAIT_RDY) & rd_ready & ~buf_full & ~cmd_abort;

    assign rd_start = (state != IDLE);
    assign busy     = (state != IDLE);
    assign rd_next  = (state == WAIT_DROP);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cmd_run && cfg_conv_bn_en) state_nx = WAIT_RDY;
            WAIT_RDY:  if (rd_ready && !buf_full)     state_nx = WAIT_DROP;
            WAIT_DROP: if (!rd_ready)                 state_nx = GAP;
            GAP:       state_nx = (fch < n_ch) ? WAIT_RDY : DRAIN;
            DRAIN:     if (buf_empty)                 state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (cmd_abort) state_nx = IDLE;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            n_ch  <= '0;
            fch   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            // Empty buffer in DRAIN means the last set has been accepted.
            done  <= (state == DRAIN) & buf_empty & ~cmd_abort;
            if (start_run) begin
                n_ch <= (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
                fch  <= '0;
            end else if ((state == WAIT_DROP) && !rd_ready && !cmd_abort) begin
                fch  <= fch + CH_W'(1);
            end
        end
    end

    assign buf_wr = '{kernel: rd_w, bn: rd_bn, ch: fch};

    weight_pingpong_buf u_buf (
        .clk     (aclk),
        .rst     (areset),
        .flush   (cmd_abort),
        .push    (capture),
        .wr_data (buf_wr),
        .pop     (cv_accept),
        .rd_data (buf_rd),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign cv_valid = ~buf_empty;
    assign cv_w     = buf_rd.kernel;
    assign cv_bn    = buf_rd.bn;
    assign cv_ch    = buf_rd.ch;

`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            chksum <= '0;
        end else if (cmd_abort || start_run) begin
            chksum <= '0;
        end else if (capture) begin
            chksum <= chksum ^ set_xor(buf_wr);
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Self-checking bench for weight_fetch_sched: a behavioural weight reader,
// a randomized consumer, a passive monitor that records transfers and
// protocol observations, and one task per scenario doing its own checks.
module tb_weight_fetch_sched;
    localparam int DW   = 32;
    localparam int CH_W = 8;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              cfg_conv_bn_en = 1'b0;
    logic [CH_W-1:0]   cfg_num_ch = '0;
    logic              cmd_run = 1'b0;
    logic              cmd_abort = 1'b0;
    logic              rd_start;
    logic              rd_ready;
    logic              rd_next;
    logic [9*DW-1:0]   rd_w;
    logic [2*DW-1:0]   rd_bn;
    logic              cv_valid;
    logic              cv_accept;
    logic [9*DW-1:0]   cv_w;
    logic [2*DW-1:0]   cv_bn;
    logic [CH_W-1:0]   cv_ch;
    logic              busy;
    logic              done;
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
    logic [DW-1:0]     chksum;
    logic [DW-1:0]     done_chk;
`endif

    weight_fetch_sched dut (
        .aclk(aclk), .areset(areset), .cfg_conv_bn_en(cfg_conv_bn_en), .cfg_num_ch(cfg_num_ch),
        .cmd_run(cmd_run), .cmd_abort(cmd_abort), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_next(rd_next), .rd_w(rd_w), .rd_bn(rd_bn), .cv_valid(cv_valid), .cv_accept(cv_accept),
        .cv_w(cv_w), .cv_bn(cv_bn), .cv_ch(cv_ch), .busy(busy), .done(done)
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // ---------------- stimulus knobs and reference model ----------------
    logic [7:0] salt = 8'h00;
    bit         data_mode = 1'b0;  // 1: checksum pattern
    int         drop_mode = -1;    // <0 random reader drop delay, else fixed
    int         acc_mode = 1;      // 0 hold off, 1 always accept, 2 random

    logic [CH_W-1:0] exp_q[$];

    function automatic logic [DW-1:0] model_word(int k, int j);
        logic [7:0] kk;
        logic [7:0] jj;
        kk = k[7:0];
        jj = j[7:0];
        if (data_mode) return (k == 1 && j == 0) ? 32'h3 : 32'h1;
        return {kk, 8'h00, salt, jj};
    endfunction

    function automatic logic [9*DW-1:0] model_w(int k);
        logic [9*DW-1:0] v;
        for (int j = 0; j < 9; j++) v[j*DW +: DW] = model_word(k, j);
        return v;
    endfunction

    function automatic logic [2*DW-1:0] model_bn(int k);
        return {model_word(k, 10), model_word(k, 9)};
    endfunction

    function automatic int eff_n(int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic build_exp(input int n);
        exp_q.delete();
        for (int k = 0; k < eff_n(n); k++) exp_q.push_back(CH_W'(k));
    endtask

    // ---------------- weight reader model ----------------
    int r_state = 0;
    int r_idx = 0;
    int r_cnt = 0;
    initial begin
        rd_ready = 1'b0;
        rd_w = '0;
        rd_bn = '0;
        forever begin
            @(posedge aclk); #1;
            if (areset || !rd_start) begin
                rd_ready = 1'b0; r_state = 0; r_idx = 0; r_cnt = 0;
            end else begin
                case (r_state)
                    0: if (!rd_next) begin
                        if (r_cnt == 0) begin
                            rd_w = model_w(r_idx); rd_bn = model_bn(r_idx);
                            rd_ready = 1'b1; r_state = 1;
                        end else r_cnt--;
                    end
                    1: if (rd_next) begin
                        r_cnt = (drop_mode >= 0) ? drop_mode : $urandom_range(0, 3);
                        r_state = 2;
                    end
                    2: if (r_cnt <= 1) begin
                        rd_ready = 1'b0; r_idx++;
                        for (int j = 0; j < 9; j++) rd_w[j*DW +: DW] = $urandom;
                        rd_bn = {$urandom, $urandom};
                        r_cnt = $urandom_range(0, 2); r_state = 3;
                    end else r_cnt--;
                    default: if (!rd_next) r_state = 0;
                endcase
            end
        end
    end

    // ---------------- consumer ----------------
    initial begin
        cv_accept = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (acc_mode)
                0:       cv_accept = 1'b0;
                1:       cv_accept = 1'b1;
                default: cv_accept = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- passive monitor ----------------
    int caps = 0, dones = 0, viol = 0, occ = 0;
    bit start_seen = 1'b0;
    bit p_next = 0, p_ready = 0, p_valid = 0, p_acc = 0, p_abort = 0;
    logic [CH_W-1:0] obs_ch_q[$];
    logic [9*DW-1:0] obs_w_q[$];
    logic [2*DW-1:0] obs_bn_q[$];
    initial begin
        forever begin
            @(negedge aclk);
            if (areset) begin
                occ = 0; p_next = 0; p_ready = 0; p_valid = 0; p_acc = 0; p_abort = 0;
            end else begin
                if (p_abort) occ = 0;
                else begin
                    if (rd_next && !p_next) begin
                        if (occ >= 2) viol++;   // captured into a full bank
                        caps++;
                        occ++;
                    end
                    if (p_valid && p_acc) occ--;
                    if (p_next && !p_ready && rd_next) viol++;  // held past rd_ready=0
                    if (p_next && p_ready && !rd_next) viol++;  // dropped early
                end
                if (cv_valid !== (occ != 0)) viol++;
                if (rd_start) start_seen = 1'b1;
                if (done) begin
                    dones++;
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
                    done_chk = chksum;
`endif
                end
                if (cv_valid && cv_accept) begin
                    obs_ch_q.push_back(cv_ch); obs_w_q.push_back(cv_w); obs_bn_q.push_back(cv_bn);
                end
                p_next = rd_next; p_ready = rd_ready; p_valid = cv_valid;
                p_acc = cv_accept; p_abort = cmd_abort;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        caps = 0; dones = 0; viol = 0; start_seen = 1'b0;
        obs_ch_q.delete(); obs_w_q.delete(); obs_bn_q.delete();
    endtask

    task automatic pulse_run(input int n, input bit en);
        @(posedge aclk); #1;
        cfg_num_ch = CH_W'(n); cfg_conv_bn_en = en; cmd_run = 1'b1;
        @(posedge aclk); #1;
        cmd_run = 1'b0;
        cfg_num_ch = CH_W'($urandom);          // must not affect the running layer
        cfg_conv_bn_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (dones != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_caps(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (caps >= target) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++; if (rd_start !== 1'b0) begin errors++; $display("FAIL reset_rd_start got=%b exp=0", rd_start); end
        checks++; if (rd_next !== 1'b0) begin errors++; $display("FAIL reset_rd_next got=%b exp=0", rd_next); end
        checks++; if (cv_valid !== 1'b0) begin errors++; $display("FAIL reset_cv_valid got=%b exp=0", cv_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (cv_ch !== '0 || cv_w !== '0 || cv_bn !== '0) begin errors++; $display("FAIL reset_cv_data got ch=%0d exp=0", cv_ch); end
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
        checks++; if (chksum !== '0) begin errors++; $display("FAIL reset_chksum got=%h exp=0", chksum); end
`endif
        @(posedge aclk); #1; areset = 1'b0;
        repeat (2) @(negedge aclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        salt = 8'($urandom); acc_mode = 1; drop_mode = -1;
        clear_mon(); build_exp(64);
        pulse_run(64, 1'b1);
        @(negedge aclk);
        checks++; if (rd_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_start got=%b%b exp=11", rd_start, busy); end
        wait_done(5000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got=0 exp=1"); end
        checks++; if (rd_start !== 1'b0) begin errors++; $display("FAIL basic_rd_start_low got=%b exp=0", rd_start); end
        @(negedge aclk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
        repeat (3) @(negedge aclk);
        checks++; if (dones !== 1 || caps !== 64) begin errors++; $display("FAIL basic_counts got dones=%0d caps=%0d exp 1 64", dones, caps); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL basic_protocol got=%0d exp=0", viol); end
        checks++; if (obs_ch_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_sets got=%0d exp=%0d", obs_ch_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_ch_q.size(); i++) begin
            checks++;
            if (obs_ch_q[i] !== exp_q[i] || obs_w_q[i] !== model_w(exp_q[i]) || obs_bn_q[i] !== model_bn(exp_q[i])) begin
                errors++; $display("FAIL basic_set%0d got ch=%0d w0=%h exp ch=%0d w0=%h", i, obs_ch_q[i], obs_w_q[i][DW-1:0], exp_q[i], model_word(exp_q[i], 0));
            end
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        salt = 8'($urandom); acc_mode = 0; drop_mode = -1;
        clear_mon(); build_exp(4);
        pulse_run(4, 1'b1);
        repeat (60) @(negedge aclk);
        checks++; if (caps !== 2) begin errors++; $display("FAIL bp_captures got=%0d exp=2", caps); end
        checks++; if (rd_ready !== 1'b1 || rd_next !== 1'b0) begin errors++; $display("FAIL bp_stall got ready=%b next=%b exp 1 0", rd_ready, rd_next); end
        checks++; if (cv_valid !== 1'b1 || cv_ch !== '0) begin errors++; $display("FAIL bp_head got v=%b ch=%0d exp 1 0", cv_valid, cv_ch); end
        acc_mode = 1;
        wait_done(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        checks++; if (caps !== 4 || viol !== 0) begin errors++; $display("FAIL bp_counts got caps=%0d viol=%0d exp 4 0", caps, viol); end
        checks++; if (obs_ch_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_sets got=%0d exp=%0d", obs_ch_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_ch_q.size(); i++) begin
            checks++;
            if (obs_ch_q[i] !== exp_q[i] || obs_w_q[i] !== model_w(exp_q[i]) || obs_bn_q[i] !== model_bn(exp_q[i])) begin
                errors++; $display("FAIL bp_set%0d got ch=%0d exp ch=%0d", i, obs_ch_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_slow_and_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            int n;
            n = (it == 0) ? 3 : $urandom_range(1, 12);
            salt = 8'($urandom); acc_mode = 2; drop_mode = (it == 0) ? 5 : -1;
            clear_mon(); build_exp(n);
            pulse_run(n, 1'b1);
            wait_done(1500, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_done_timeout got=0 exp=1", it); end
            checks++; if (caps !== eff_n(n) || viol !== 0) begin errors++; $display("FAIL rnd%0d_counts got caps=%0d viol=%0d exp %0d 0", it, caps, viol, eff_n(n)); end
            checks++; if (obs_ch_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_sets got=%0d exp=%0d", it, obs_ch_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_ch_q.size(); i++) begin
                checks++;
                if (obs_ch_q[i] !== exp_q[i] || obs_w_q[i] !== model_w(exp_q[i]) || obs_bn_q[i] !== model_bn(exp_q[i])) begin
                    errors++; $display("FAIL rnd%0d_set%0d got ch=%0d exp ch=%0d", it, i, obs_ch_q[i], exp_q[i]);
                end
            end
        end
        drop_mode = -1;
    endtask

    task automatic test_abort();
        bit ok;
        salt = 8'($urandom); acc_mode = 1; drop_mode = -1;
        clear_mon();
        pulse_run(8, 1'b1);
        wait_caps(3, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_caps_timeout got=%0d exp=3", caps); end
        @(posedge aclk); #1; cmd_abort = 1'b1;
        @(posedge aclk); #1; cmd_abort = 1'b0;
        @(negedge aclk);
        checks++; if (rd_start !== 1'b0 || rd_next !== 1'b0) begin errors++; $display("FAIL abort_reader got start=%b next=%b exp 0 0", rd_start, rd_next); end
        checks++; if (cv_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got valid=%b busy=%b exp 0 0", cv_valid, busy); end
        repeat (10) @(negedge aclk);
        checks++; if (dones !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done got dones=%0d busy=%b exp 0 0", dones, busy); end
        clear_mon(); build_exp(2);
        pulse_run(2, 1'b1);
        wait_done(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout got=0 exp=1"); end
        checks++; if (obs_ch_q.size() !== 2) begin errors++; $display("FAIL abort_restart_sets got=%0d exp=2", obs_ch_q.size()); end
        else begin
            checks++;
            if (obs_ch_q[0] !== exp_q[0] || obs_w_q[0] !== model_w(0) || obs_ch_q[1] !== exp_q[1]) begin
                errors++; $display("FAIL abort_restart_order got ch=%0d,%0d exp 0,1", obs_ch_q[0], obs_ch_q[1]);
            end
        end
    endtask

    task automatic test_edge_cfg();
        bit ok;
        salt = 8'($urandom); acc_mode = 2;
        clear_mon(); build_exp(0);
        pulse_run(0, 1'b1);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_ch_done_timeout got=0 exp=1"); end
        repeat (3) @(negedge aclk);
        checks++; if (caps !== 1 || dones !== 1) begin errors++; $display("FAIL zero_ch_counts got caps=%0d dones=%0d exp 1 1", caps, dones); end
        checks++; if (obs_ch_q.size() !== 1 || obs_ch_q[0] !== exp_q[0] || obs_bn_q[0] !== model_bn(0)) begin
            errors++; $display("FAIL zero_ch_set got n=%0d exp=1", obs_ch_q.size());
        end
        clear_mon();
        pulse_run(5, 1'b0);
        repeat (10) @(negedge aclk);
        checks++; if (start_seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_off got seen=%b busy=%b exp 0 0", start_seen, busy); end
        clear_mon();
        @(posedge aclk); #1;
        cfg_num_ch = 8'd3; cfg_conv_bn_en = 1'b1; cmd_run = 1'b1; cmd_abort = 1'b1;
        @(posedge aclk); #1;
        cmd_run = 1'b0; cmd_abort = 1'b0;
        repeat (10) @(negedge aclk);
        checks++; if (start_seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL run_abort got seen=%b busy=%b exp 0 0", start_seen, busy); end
    endtask

`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
    task automatic test_checksum();
        bit ok;
        data_mode = 1'b1; acc_mode = 2;
        clear_mon();
        pulse_run(2, 1'b1);
        wait_done(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chk_done_timeout got=0 exp=1"); end
        checks++; if (done_chk !== 32'h2) begin errors++; $display("FAIL chk_at_done got=%h exp=00000002", done_chk); end
        repeat (5) @(negedge aclk);
        checks++; if (chksum !== 32'h2) begin errors++; $display("FAIL chk_held got=%h exp=00000002", chksum); end
        data_mode = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        bit ok;
        salt = 8'($urandom); acc_mode = 1;
        clear_mon();
        pulse_run(8, 1'b1);
        wait_caps(2, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_caps_timeout got=%0d exp=2", caps); end
        @(posedge aclk); #2; areset = 1'b1;
        #1;
        checks++; if (rd_start !== 1'b0 || rd_next !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_ctrl got start=%b next=%b busy=%b exp 0 0 0", rd_start, rd_next, busy);
        end
        checks++; if (cv_valid !== 1'b0 || done !== 1'b0 || cv_ch !== '0 || cv_w !== '0 || cv_bn !== '0) begin
            errors++; $display("FAIL areset_cv got valid=%b ch=%0d exp 0 0", cv_valid, cv_ch);
        end
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
        checks++; if (chksum !== '0) begin errors++; $display("FAIL areset_chksum got=%h exp=0", chksum); end
`endif
        @(posedge aclk); #1; areset = 1'b0;
        repeat (5) @(negedge aclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_stays_idle got=%b exp=0", busy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_slow_and_random();
        test_abort();
        test_edge_cfg();
`ifdef WEIGHT_FETCH_SCHED_CHKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
